// File: rtl/gray_count_ctrl_pkg.sv
// Shared types and helpers for the Gray counter sequencer.
// State encoding and the binary-to-Gray conversion.
package gray_ctrl_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    // Callers zero-extend up to MAX_W and truncate the result to their width;
    // the extension leaves the low bits of the Gray code unchanged.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_count_ctrl_if.sv
// Command/config/status bundle of the Gray counter sequencer.
// master drives commands and reads status; slave is the sequencer.
interface gray_count_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             pause;
    logic [WIDTH-1:0] cfg_limit;
    logic             cfg_oneshot;
    logic [WIDTH-1:0] bin_count;
    logic [WIDTH-1:0] gray_count;
    logic             busy;
    logic             done;
    logic             wrap;
    logic [1:0]       state;

    modport master (
        output start, stop, pause, cfg_limit, cfg_oneshot,
        input  bin_count, gray_count, busy, done, wrap, state
    );

    modport slave (
        input  start, stop, pause, cfg_limit, cfg_oneshot,
        output bin_count, gray_count, busy, done, wrap, state
    );
endinterface

// File: rtl/gray_count_ctrl_core.sv
// Registered binary counter with a registered Gray twin.
// Gray is encoded from the next binary value so both flops agree every cycle.
module gray_counter_core
    import gray_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_bin,
    output logic [WIDTH-1:0] o_gray
);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic [WIDTH-1:0] w_next;

    // Next count: clear wins, else increment, else hold.
    always_comb begin
        w_next = r_bin;
        if (i_clr)
            w_next = '0;
        else if (i_inc)
            w_next = r_bin + 1'b1;
    end

    // Count and its Gray code registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else begin
            r_bin  <= w_next;
            r_gray <= WIDTH'(bin2gray(MAX_W'(w_next)));
        end
    end

    assign o_bin  = r_bin;
    assign o_gray = r_gray;

endmodule

// File: rtl/gray_count_ctrl.sv
// Start/pause/stop sequencer around the Gray counter core.
// Counts 0..limit, then finishes (one-shot) or wraps (free-run).
module gray_count_ctrl
    import gray_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    gray_count_ctrl_if.slave bus
);

    state_t           r_state;
    logic [WIDTH-1:0] r_limit;
    logic             r_oneshot;
    logic             r_busy;
    logic             r_done;
    logic             r_wrap;

    state_t           w_state_nxt;
    logic             w_clr;
    logic             w_inc;
    logic             w_wrap_nxt;
    logic             w_at_lim;
    logic             w_accept;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_gray;

    assign w_at_lim = (w_bin == r_limit);
    assign w_accept = (r_state == IDLE) && bus.start && !bus.stop;

    // Next state and counter controls; stop beats pause beats advance.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        w_wrap_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_clr = 1'b1;
                if (w_accept)
                    w_state_nxt = RUN;
            end
            RUN: begin
                if (bus.stop) begin
                    w_clr       = 1'b1;
                    w_state_nxt = IDLE;
                end else if (bus.pause) begin
                    w_state_nxt = HOLD;
                end else if (!w_at_lim) begin
                    w_inc = 1'b1;
                end else if (r_oneshot) begin
                    w_state_nxt = DONE;
                end else begin
                    w_clr      = 1'b1;
                    w_wrap_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (bus.stop) begin
                    w_clr       = 1'b1;
                    w_state_nxt = IDLE;
                end else if (!bus.pause) begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                w_clr       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_clr       = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state, registered status and config latched on an accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_limit   <= '0;
            r_oneshot <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == RUN) || (w_state_nxt == HOLD);
            r_done  <= (w_state_nxt == DONE);
            r_wrap  <= w_wrap_nxt;
            if (w_accept) begin
                r_limit   <= bus.cfg_limit;
                r_oneshot <= bus.cfg_oneshot;
            end
        end
    end

    gray_counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_inc  (w_inc),
        .o_bin  (w_bin),
        .o_gray (w_gray)
    );

    assign bus.bin_count  = w_bin;
    assign bus.gray_count = w_gray;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.wrap       = r_wrap;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_gray_count_ctrl.sv
// Directed self-checking bench for gray_count_ctrl (WIDTH=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_gray_count_ctrl;

    localparam int W = 4;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    logic [3:0] prev_g;

    logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hc, 4'hd, 4'hf, 4'he, 4'ha, 4'hb, 4'h9, 4'h8};

    gray_count_ctrl_if #(.WIDTH(W)) bus ();

    gray_count_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input int st, input int cnt,
                       input logic [3:0] g, input logic bsy);
        check({tag, ".state"}, 32'(bus.state), 32'(st));
        check({tag, ".bin"},   32'(bus.bin_count), 32'(cnt));
        check({tag, ".gray"},  32'(bus.gray_count), 32'(g));
        check({tag, ".busy"},  32'(bus.busy), 32'(bsy));
    endtask

    task automatic go(input logic [3:0] lim, input logic os);
        bus.cfg_limit   = lim;
        bus.cfg_oneshot = os;
        bus.start       = 1'b1;
        step();
        bus.start       = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.pause = 1'b0;
        bus.cfg_limit = '0;
        bus.cfg_oneshot = 1'b0;
        step();
        step();
        chk("rst", 0, 0, 4'h0, 1'b0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.wrap", 32'(bus.wrap), 32'd0);
        reset = 1'b0;
        step();
        chk("idle", 0, 0, 4'h0, 1'b0);

        // one-shot, limit 5
        go(4'd5, 1'b1);
        chk("os.k0", 1, 0, 4'h0, 1'b1);
        prev_g = 4'h0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("os.k%0d", k), 1, k, gtab[k], 1'b1);
            check("os.onebit", $countones(bus.gray_count ^ prev_g), 1);
            prev_g = bus.gray_count;
        end
        step();
        chk("os.done", 3, 5, 4'h7, 1'b0);
        check("os.donepulse", 32'(bus.done), 32'd1);
        step();
        chk("os.idle", 0, 0, 4'h0, 1'b0);
        check("os.donelow", 32'(bus.done), 32'd0);

        // free-run, limit 15
        go(4'd15, 1'b0);
        chk("fr.k0", 1, 0, 4'h0, 1'b1);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk($sformatf("fr.k%0d", k), 1, k, gtab[k], 1'b1);
            check("fr.nowrap", 32'(bus.wrap), 32'd0);
        end
        prev_g = bus.gray_count;
        step();
        chk("fr.wrap0", 1, 0, 4'h0, 1'b1);
        check("fr.wrap", 32'(bus.wrap), 32'd1);
        check("fr.wrapbit", $countones(bus.gray_count ^ prev_g), 1);
        step();
        chk("fr.after", 1, 1, 4'h1, 1'b1);
        check("fr.wrapoff", 32'(bus.wrap), 32'd0);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("fr.stop", 0, 0, 4'h0, 1'b0);

        // free-run limit 7 with pause at count 3
        go(4'd7, 1'b0);
        step();
        step();
        step();
        chk("pz.k3", 1, 3, 4'h2, 1'b1);
        bus.pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("pz.hold%0d", i), 2, 3, 4'h2, 1'b1);
        end
        bus.pause = 1'b0;
        step();
        chk("pz.resume", 1, 3, 4'h2, 1'b1);
        step();
        chk("pz.k4", 1, 4, 4'h6, 1'b1);

        // start while running: ignored, limit 7 free-run kept
        bus.cfg_limit   = 4'd2;
        bus.cfg_oneshot = 1'b1;
        bus.start       = 1'b1;
        step();
        bus.start       = 1'b0;
        chk("ign.k5", 1, 5, 4'h7, 1'b1);
        step();
        step();
        chk("ign.k7", 1, 7, 4'h4, 1'b1);
        step();
        chk("ign.wrap0", 1, 0, 4'h0, 1'b1);
        check("ign.wrap", 32'(bus.wrap), 32'd1);
        bus.stop = 1'b1;
        step();
        chk("ign.stop", 0, 0, 4'h0, 1'b0);

        // start together with stop in IDLE
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("ss.idle", 0, 0, 4'h0, 1'b0);
        step();
        chk("ss.idle2", 0, 0, 4'h0, 1'b0);

        // asynchronous reset mid-run at count 5
        go(4'd9, 1'b0);
        for (int i = 0; i < 5; i++) step();
        chk("ar.k5", 1, 5, 4'h7, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar.async", 0, 0, 4'h0, 1'b0);
        step();
        reset = 1'b0;
        step();
        chk("ar.idle", 0, 0, 4'h0, 1'b0);

        // limit 0 one-shot
        go(4'd0, 1'b1);
        chk("l0os.run", 1, 0, 4'h0, 1'b1);
        step();
        chk("l0os.done", 3, 0, 4'h0, 1'b0);
        check("l0os.pulse", 32'(bus.done), 32'd1);
        step();
        chk("l0os.idle", 0, 0, 4'h0, 1'b0);

        // limit 0 free-run
        go(4'd0, 1'b0);
        chk("l0fr.run", 1, 0, 4'h0, 1'b1);
        check("l0fr.w0", 32'(bus.wrap), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("l0fr.c%0d", i), 1, 0, 4'h0, 1'b1);
            check($sformatf("l0fr.wrap%0d", i), 32'(bus.wrap), 32'd1);
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("l0fr.stop", 0, 0, 4'h0, 1'b0);
        check("l0fr.wrapoff", 32'(bus.wrap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
